// File: rtl/step_detector.sv
// Step detector: smooths acceleration samples, then counts rise/fall peaks whose spacing is plausible.
// Optional smoothing filter is enabled by defining STEP_SMOOTH_EN; otherwise the sample is used directly.
module step_detector #(
    parameter logic [7:0] SAT_MAX = 8'd255
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sampleValid,
    input  logic [7:0] sample,
    input  logic [7:0] theta1,
    input  logic [7:0] theta2,
    input  logic [7:0] beta1,
    input  logic [7:0] beta2,
    input  logic [7:0] alpha1,
    input  logic [7:0] totalSteps,
    output logic [7:0] updatedSteps,
    output logic       updateTotalSteps,
    output logic [1:0] fsmState
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1
    } state_e;

    state_e     state_q, state_d;
    logic [7:0] filt_q, filt_d;
    logic       filt_valid_q, filt_valid_d;
    logic [7:0] cnt_q, cnt_d;
    logic       first_step_q, first_step_d;
    logic [7:0] updated_steps_q, updated_steps_d;
    logic       update_total_q, update_total_d;

    logic [7:0] filt_next;
    logic [7:0] cnt_inc;
    logic [7:0] steps_inc;
    logic       in_window;

`ifdef STEP_SMOOTH_EN
    // Difference is 9-bit signed so a falling input shifts toward the sample, not away from it.
    logic signed [8:0] filt_diff;
    logic signed [8:0] filt_step;
    logic              smooth_unused;

    assign filt_diff     = $signed({1'b0, sample}) - $signed({1'b0, filt_q});
    assign filt_step     = filt_diff >>> alpha1[1:0];
    assign filt_next     = filt_q + filt_step[7:0];
    assign smooth_unused = ^{alpha1[7:2], filt_step[8]};
`else
    logic alpha_unused;

    assign filt_next    = sample;
    assign alpha_unused = ^alpha1;
`endif

    assign cnt_inc   = (cnt_q < SAT_MAX) ? cnt_q + 8'd1 : SAT_MAX;
    assign steps_inc = (totalSteps >= SAT_MAX) ? SAT_MAX : totalSteps + 8'd1;
    assign in_window = (cnt_q >= beta1) && (cnt_q <= beta2);

    always_comb begin
        // NOTE: every signal gets a default first so no path through the block can infer a latch.
        filt_d          = filt_q;
        filt_valid_d    = sampleValid;
        state_d         = state_q;
        cnt_d           = cnt_q;
        first_step_d    = first_step_q;
        updated_steps_d = updated_steps_q;
        update_total_d  = 1'b0;

        if (sampleValid) begin
            filt_d = filt_next;
        end

        if (filt_valid_q) begin
            cnt_d = cnt_inc;
            case (state_q)
                IDLE: begin
                    // A long quiet spell means the next peak starts a fresh walk.
                    if (cnt_q > beta2) begin
                        first_step_d = 1'b1;
                    end
                    if (filt_q > theta1) begin
                        state_d = HIGH;
                    end
                end
                HIGH: begin
                    if (filt_q < theta2) begin
                        state_d = IDLE;
                        if (first_step_q || in_window) begin
                            cnt_d           = 8'd0;
                            first_step_d    = 1'b0;
                            updated_steps_d = steps_inc;
                            update_total_d  = 1'b1;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // NOTE: reset is asynchronous, so an in-flight sample or pending strobe is dropped immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            filt_q          <= 8'd0;
            filt_valid_q    <= 1'b0;
            state_q         <= IDLE;
            cnt_q           <= 8'd0;
            first_step_q    <= 1'b1;
            updated_steps_q <= 8'd0;
            update_total_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the pre-edge value of its peers.
            filt_q          <= filt_d;
            filt_valid_q    <= filt_valid_d;
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            first_step_q    <= first_step_d;
            updated_steps_q <= updated_steps_d;
            update_total_q  <= update_total_d;
        end
    end

    assign updatedSteps     = updated_steps_q;
    assign updateTotalSteps = update_total_q;
    assign fsmState         = state_q;

endmodule
